// File: rtl/draw_layer_arbiter.sv
// Per-pixel layer priority mux (1-cycle registered) and per-frame ball collision monitor.
// Optional build macro COLLISION_COUNT_EN adds a saturating collision-pixel counter output.
module draw_layer_arbiter #(
  parameter int          N_LAYERS    = 4,
  parameter logic [7:0]  TRANSPARENT = 8'hFF,
  parameter int          X_MAX       = 639,
  parameter int          Y_MAX       = 479
) (
  input  logic                    CLK,
  input  logic                    RESETn,
  input  logic                    startOfFrame,
  input  logic [10:0]             oCoord_X,
  input  logic [10:0]             oCoord_Y,
  input  logic [7:0]              bg_rgb,
  input  logic [N_LAYERS-1:0]     layer_req,
  input  logic [8*N_LAYERS-1:0]   layer_rgb,
  output logic [7:0]              mVGA_RGB,
  output logic                    collision_valid,
  output logic [N_LAYERS-1:0]     collision_mask,
  output logic [10:0]             first_hit_x,
  output logic [10:0]             first_hit_y
`ifdef COLLISION_COUNT_EN
  ,
  output logic [15:0]             collision_count
`endif
);

  typedef enum logic [1:0] {
    WAIT_SOF = 2'd0,
    ACTIVE   = 2'd1,
    REPORT   = 2'd2
  } state_t;

  localparam logic [10:0] X_LIM = 11'(X_MAX);
  localparam logic [10:0] Y_LIM = 11'(Y_MAX);

  state_t                state_r, state_next_s;
  logic                  visible_s;
  logic [N_LAYERS-1:0]   valid_s;
  logic [N_LAYERS-1:0]   hit_vec_s;
  logic                  coll_s;
  logic                  acc_en_s;
  logic                  frame_edge_s;
  logic [7:0]            pix_s;
  logic [N_LAYERS-1:0]   acc_mask_r;
  logic                  hit_seen_r;
  logic [10:0]           hit_x_r;
  logic [10:0]           hit_y_r;

  // Layer validity, priority select and ball-overlap detection
  always_comb begin
    visible_s = (oCoord_X <= X_LIM) && (oCoord_Y <= Y_LIM);
    valid_s   = '0;
    hit_vec_s = '0;
    pix_s     = bg_rgb;
    for (int i = 0; i < N_LAYERS; i++) begin
      valid_s[i] = layer_req[i] && (layer_rgb[8*i +: 8] != TRANSPARENT) && visible_s;
    end
    // Walk from lowest priority upward so the lowest valid index ends up winning
    for (int i = N_LAYERS-1; i >= 0; i--) begin
      if (valid_s[i]) begin
        pix_s = layer_rgb[8*i +: 8];
      end else begin
        pix_s = pix_s;
      end
    end
    if (!visible_s) begin
      pix_s = 8'h00;
    end else begin
      pix_s = pix_s;
    end
    for (int j = 1; j < N_LAYERS; j++) begin
      hit_vec_s[j] = valid_s[0] && valid_s[j];
    end
    coll_s       = |hit_vec_s;
    acc_en_s     = (state_r == ACTIVE) || (state_r == REPORT);
    frame_edge_s = startOfFrame && acc_en_s;
  end

  // Frame-tracking next-state logic
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      WAIT_SOF: state_next_s = startOfFrame ? ACTIVE : WAIT_SOF;
      ACTIVE:   state_next_s = startOfFrame ? REPORT : ACTIVE;
      REPORT:   state_next_s = startOfFrame ? REPORT : ACTIVE;
      default:  state_next_s = WAIT_SOF;
    endcase
  end

  // State register
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state_r <= WAIT_SOF;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Registered pixel output
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      mVGA_RGB <= 8'h00;
    end else begin
      mVGA_RGB <= pix_s;
    end
  end

  // Per-frame accumulator; a hit on the boundary pixel seeds the new frame
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      acc_mask_r <= '0;
      hit_seen_r <= 1'b0;
      hit_x_r    <= 11'd0;
      hit_y_r    <= 11'd0;
    end else if (frame_edge_s) begin
      acc_mask_r <= hit_vec_s;
      hit_seen_r <= coll_s;
      if (coll_s) begin
        hit_x_r <= oCoord_X;
        hit_y_r <= oCoord_Y;
      end
    end else if (acc_en_s) begin
      acc_mask_r <= acc_mask_r | hit_vec_s;
      if (coll_s && !hit_seen_r) begin
        hit_seen_r <= 1'b1;
        hit_x_r    <= oCoord_X;
        hit_y_r    <= oCoord_Y;
      end
    end else begin
      acc_mask_r <= '0;
      hit_seen_r <= 1'b0;
    end
  end

  // Report registers, latched at each frame boundary
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      collision_valid <= 1'b0;
      collision_mask  <= '0;
      first_hit_x     <= 11'd0;
      first_hit_y     <= 11'd0;
    end else if (frame_edge_s) begin
      collision_valid <= |acc_mask_r;
      collision_mask  <= acc_mask_r;
      if (hit_seen_r) begin
        first_hit_x <= hit_x_r;
        first_hit_y <= hit_y_r;
      end
    end else begin
      collision_valid <= 1'b0;
    end
  end

`ifdef COLLISION_COUNT_EN
  logic [15:0] count_acc_r;

  // Saturating collision-pixel counter and its per-frame snapshot
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      count_acc_r     <= 16'd0;
      collision_count <= 16'd0;
    end else if (frame_edge_s) begin
      count_acc_r     <= coll_s ? 16'd1 : 16'd0;
      collision_count <= count_acc_r;
    end else if (acc_en_s) begin
      if (coll_s && (count_acc_r != 16'hFFFF)) begin
        count_acc_r <= count_acc_r + 16'd1;
      end
    end else begin
      count_acc_r <= 16'd0;
    end
  end
`endif

endmodule

// File: tb/tb_draw_layer_arbiter.sv
// Directed self-checking bench for draw_layer_arbiter.
module tb_draw_layer_arbiter;

  logic        CLK;
  logic        RESETn;
  logic        startOfFrame;
  logic [10:0] oCoord_X;
  logic [10:0] oCoord_Y;
  logic [7:0]  bg_rgb;
  logic [3:0]  layer_req;
  logic [31:0] layer_rgb;
  logic [7:0]  mVGA_RGB;
  logic        collision_valid;
  logic [3:0]  collision_mask;
  logic [10:0] first_hit_x;
  logic [10:0] first_hit_y;
`ifdef COLLISION_COUNT_EN
  logic [15:0] collision_count;
`endif

  int pass_cnt  = 0;
  int total_cnt = 0;

  draw_layer_arbiter dut (
    .CLK             (CLK),
    .RESETn          (RESETn),
    .startOfFrame    (startOfFrame),
    .oCoord_X        (oCoord_X),
    .oCoord_Y        (oCoord_Y),
    .bg_rgb          (bg_rgb),
    .layer_req       (layer_req),
    .layer_rgb       (layer_rgb),
    .mVGA_RGB        (mVGA_RGB),
    .collision_valid (collision_valid),
    .collision_mask  (collision_mask),
    .first_hit_x     (first_hit_x),
    .first_hit_y     (first_hit_y)
`ifdef COLLISION_COUNT_EN
    ,
    .collision_count (collision_count)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) begin
      pass_cnt++;
    end else begin
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one pixel, then sample 1 time unit after the capturing edge
  task automatic px(input logic [10:0] x, input logic [10:0] y,
                    input logic [3:0] req, input logic sof);
    oCoord_X     = x;
    oCoord_Y     = y;
    layer_req    = req;
    startOfFrame = sof;
    @(posedge CLK);
    #1;
    startOfFrame = 1'b0;
  endtask

  initial begin
    RESETn       = 1'b0;
    startOfFrame = 1'b0;
    oCoord_X     = 11'd0;
    oCoord_Y     = 11'd0;
    bg_rgb       = 8'h0D;
    layer_req    = 4'b0000;
    layer_rgb    = {8'h42, 8'h1C, 8'h03, 8'hE0};
    repeat (2) @(posedge CLK);
    #1;
    check("reset_rgb",   32'(mVGA_RGB),        32'h00);
    check("reset_valid", 32'(collision_valid), 32'h0);
    check("reset_mask",  32'(collision_mask),  32'h0);
    check("reset_hitx",  32'(first_hit_x),     32'h0);
    check("reset_hity",  32'(first_hit_y),     32'h0);
    RESETn = 1'b1;

    // 1: background only, first SOF after reset reports nothing
    px(11'd100, 11'd100, 4'b0000, 1'b1);
    check("t1_rgb",   32'(mVGA_RGB),        32'h0D);
    check("t1_valid", 32'(collision_valid), 32'h0);

    // 2: ball over layer 2
    px(11'd50, 11'd60, 4'b0101, 1'b0);
    check("t2_rgb", 32'(mVGA_RGB), 32'hE0);
    px(11'd100, 11'd100, 4'b0000, 1'b0);
    px(11'd100, 11'd100, 4'b0000, 1'b1);
    check("t2_valid", 32'(collision_valid), 32'h1);
    check("t2_mask",  32'(collision_mask),  32'h4);
    check("t2_hitx",  32'(first_hit_x),     32'd50);
    check("t2_hity",  32'(first_hit_y),     32'd60);
    px(11'd100, 11'd100, 4'b0000, 1'b0);
    check("t2_pulse_end", 32'(collision_valid), 32'h0);
    check("t2_mask_hold", 32'(collision_mask),  32'h4);

    // 3: transparent ball shows layer 1 and is no collision
    layer_rgb[7:0] = 8'hFF;
    px(11'd30, 11'd30, 4'b0011, 1'b0);
    check("t3_rgb", 32'(mVGA_RGB), 32'h03);
    layer_rgb[7:0] = 8'hE0;
    px(11'd100, 11'd100, 4'b0000, 1'b1);
    check("t3_valid", 32'(collision_valid), 32'h0);
    check("t3_mask",  32'(collision_mask),  32'h0);
    check("t3_hitx_hold", 32'(first_hit_x), 32'd50);

    // 4: first-hit capture and collision on the SOF pixel
    px(11'd10, 11'd10, 4'b0011, 1'b0);
    px(11'd20, 11'd20, 4'b1001, 1'b0);
    check("t4_rgb", 32'(mVGA_RGB), 32'hE0);
    px(11'd0, 11'd0, 4'b0011, 1'b1);
    check("t4_valid", 32'(collision_valid), 32'h1);
    check("t4_mask",  32'(collision_mask),  32'hA);
    check("t4_hitx",  32'(first_hit_x),     32'd10);
    check("t4_hity",  32'(first_hit_y),     32'd10);
`ifdef COLLISION_COUNT_EN
    check("t4_count", 32'(collision_count), 32'd2);
`endif
    px(11'd100, 11'd100, 4'b0000, 1'b0);
    px(11'd100, 11'd100, 4'b0000, 1'b1);
    check("t4b_valid", 32'(collision_valid), 32'h1);
    check("t4b_mask",  32'(collision_mask),  32'h2);
    check("t4b_hitx",  32'(first_hit_x),     32'd0);
    check("t4b_hity",  32'(first_hit_y),     32'd0);
`ifdef COLLISION_COUNT_EN
    check("t4b_count", 32'(collision_count), 32'd1);
`endif

    // 5: reset mid-frame discards accumulation
    px(11'd5, 11'd5, 4'b0011, 1'b0);
    RESETn = 1'b0;
    #2;
    check("t5_rst_mask", 32'(collision_mask), 32'h0);
    @(posedge CLK);
    #1;
    RESETn = 1'b1;
    px(11'd100, 11'd100, 4'b0000, 1'b1);
    check("t5_sof1_valid", 32'(collision_valid), 32'h0);
    px(11'd100, 11'd100, 4'b0000, 1'b0);
    px(11'd100, 11'd100, 4'b0000, 1'b1);
    check("t5_sof2_valid", 32'(collision_valid), 32'h0);
    check("t5_mask",       32'(collision_mask),  32'h0);
    check("t5_hitx",       32'(first_hit_x),     32'd0);

    // 6: visibility boundaries; three collision pixels for the counter
    px(11'd700, 11'd100, 4'b0011, 1'b0);
    check("t6_x700_rgb", 32'(mVGA_RGB), 32'h00);
    px(11'd639, 11'd479, 4'b0010, 1'b0);
    check("t6_edge_rgb", 32'(mVGA_RGB), 32'h03);
    px(11'd100, 11'd480, 4'b0001, 1'b0);
    check("t6_y480_rgb", 32'(mVGA_RGB), 32'h00);
    px(11'd1, 11'd1, 4'b0011, 1'b0);
    px(11'd2, 11'd1, 4'b0101, 1'b0);
    px(11'd3, 11'd1, 4'b1001, 1'b0);
    px(11'd100, 11'd100, 4'b0000, 1'b1);
    check("t6_valid", 32'(collision_valid), 32'h1);
    check("t6_mask",  32'(collision_mask),  32'hE);
    check("t6_hitx",  32'(first_hit_x),     32'd1);
`ifdef COLLISION_COUNT_EN
    check("t6_count", 32'(collision_count), 32'd3);
`endif

    // SOF during REPORT: a one-pixel frame is reported immediately
    px(11'd100, 11'd100, 4'b0000, 1'b0);
    check("t7_idle_rgb", 32'(mVGA_RGB), 32'h0D);
    px(11'd7, 11'd8, 4'b0101, 1'b1);
    check("t7_a_valid", 32'(collision_valid), 32'h0);
    px(11'd100, 11'd100, 4'b0000, 1'b1);
    check("t7_b_valid", 32'(collision_valid), 32'h1);
    check("t7_b_mask",  32'(collision_mask),  32'h4);
    check("t7_b_hitx",  32'(first_hit_x),     32'd7);
    check("t7_b_hity",  32'(first_hit_y),     32'd8);
    px(11'd100, 11'd100, 4'b0000, 1'b0);
    check("t7_c_valid", 32'(collision_valid), 32'h0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
